// File: rtl/approx_err_monitor.sv
// Error-statistics stage behind the approximate radix-4 Booth multiplier: sums, maxes and counts |p_approx - x*y| over 2^LOG_N samples.
// Optional macro ERR_SIGNED_SUM_EN adds a signed error accumulator (sum_err) for bias measurement.
module approx_err_monitor #(
  parameter int WL    = 8,
  parameter int LOG_N = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WL-1:0]             x,
  input  logic [WL-1:0]             y,
  input  logic [2*WL-1:0]           p_approx,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*WL+LOG_N:0]       sum_abs_err,
  output logic [2*WL:0]             max_abs_err,
`ifdef ERR_SIGNED_SUM_EN
  output logic signed [2*WL+LOG_N:0] sum_err,
`endif
  output logic [LOG_N:0]            err_count
);

  localparam int PW    = 2 * WL;
  localparam int ERR_W = PW + 1;
  localparam int SUM_W = ERR_W + LOG_N;
  localparam int CNT_W = LOG_N + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG_N) - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_in_ready;
  logic               r_res_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic [SUM_W-1:0]   r_sum;
  logic [ERR_W-1:0]   r_max;
  logic [CNT_W-1:0]   r_errcnt;
`ifdef ERR_SIGNED_SUM_EN
  logic [SUM_W-1:0]   r_serr;
`endif

  logic signed [PW-1:0] w_xe;
  logic signed [PW-1:0] w_ye;
  logic [PW-1:0]        w_exact;
  logic [ERR_W-1:0]     w_err;
  logic [ERR_W-1:0]     w_abs;
  logic                 w_nonzero;
  logic                 w_last;

  // Operands are sign-extended so the low PW bits of the product are the exact signed product.
  assign w_xe      = {{WL{x[WL-1]}}, x};
  assign w_ye      = {{WL{y[WL-1]}}, y};
  assign w_exact   = w_xe * w_ye;
  assign w_err     = {p_approx[PW-1], p_approx} - {w_exact[PW-1], w_exact};
  assign w_abs     = w_err[ERR_W-1] ? (~w_err + ERR_W'(1)) : w_err;
  assign w_nonzero = |w_err;
  assign w_last    = (r_cnt == LAST_IDX);

  // Window control and accumulators; every accepted sample updates all statistics on its own edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_max       <= '0;
      r_errcnt    <= '0;
`ifdef ERR_SIGNED_SUM_EN
      r_serr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_max      <= '0;
            r_errcnt   <= '0;
`ifdef ERR_SIGNED_SUM_EN
            r_serr     <= '0;
`endif
          end
        end
        S_RUN: begin
          if (in_valid) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_sum    <= r_sum + {{LOG_N{1'b0}}, w_abs};
            r_errcnt <= r_errcnt + {{LOG_N{1'b0}}, w_nonzero};
            if (w_abs > r_max) begin
              r_max <= w_abs;
            end
`ifdef ERR_SIGNED_SUM_EN
            r_serr   <= r_serr + {{LOG_N{w_err[ERR_W-1]}}, w_err};
`endif
            if (w_last) begin
              r_state     <= S_REPORT;
              r_in_ready  <= 1'b0;
              r_res_valid <= 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign in_ready    = r_in_ready;
  assign res_valid   = r_res_valid;
  assign sum_abs_err = r_sum;
  assign max_abs_err = r_max;
  assign err_count   = r_errcnt;
`ifdef ERR_SIGNED_SUM_EN
  assign sum_err     = $signed(r_serr);
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomised bench for approx_err_monitor: per-cycle comparison against an arithmetic window model plus literal pins.
module tb_approx_err_monitor;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  x = 8'sd0;
  logic signed [7:0]  y = 8'sd0;
  logic signed [15:0] p = 16'sd0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [24:0]        sum_abs_err;
  logic [16:0]        max_abs_err;
  logic [8:0]         err_count;
`ifdef ERR_SIGNED_SUM_EN
  logic signed [24:0] sum_err;
`endif

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 collecting, 2 reporting.
  int     m_phase = 0;
  int     m_n     = 0;
  longint m_sum   = 0;
  longint m_max   = 0;
  longint m_cnt   = 0;
  longint m_serr  = 0;

  approx_err_monitor #(.WL(8), .LOG_N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .p_approx(p),
    .res_valid(res_valid), .res_ready(res_ready),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
`ifdef ERR_SIGNED_SUM_EN
    .sum_err(sum_err),
`endif
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: check outputs against the model, then advance the model with the inputs the next edge sees.
  initial begin
    longint e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0; m_n = 0; m_sum = 0; m_max = 0; m_cnt = 0; m_serr = 0;
      end
      chk("busy",      longint'(busy),      longint'(m_phase != 0));
      chk("in_ready",  longint'(in_ready),  longint'(m_phase == 1));
      chk("res_valid", longint'(res_valid), longint'(m_phase == 2));
      chk("sum_abs",   longint'(sum_abs_err), m_sum);
      chk("max_abs",   longint'(max_abs_err), m_max);
      chk("err_cnt",   longint'(err_count),   m_cnt);
`ifdef ERR_SIGNED_SUM_EN
      chk("sum_err",   longint'(sum_err),     m_serr);
`endif
      if (rst_n) begin
        case (m_phase)
          0: if (start) begin
               m_phase = 1; m_n = 0; m_sum = 0; m_max = 0; m_cnt = 0; m_serr = 0;
             end
          1: if (in_valid) begin
               e = longint'(p) - longint'(x) * longint'(y);
               m_serr += e;
               if (e < 0) e = -e;
               m_sum += e;
               if (e > m_max) m_max = e;
               if (e != 0) m_cnt++;
               m_n++;
               if (m_n == 256) m_phase = 2;
             end
          default: if (res_ready) m_phase = 0;
        endcase
      end
    end
  end

  // mode 0: exact products, 1: exact+1, 2: one worst-case error at sample 37.
  task automatic run_window(input int mode, input bit toggle, input int start_at, input int rst_at,
                            input int hold, input bit rr_early,
                            input longint es, input longint em, input longint ec);
    int k;
    int guard;
    bit v;
    longint ex;
    res_ready = rr_early;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    guard = 0;
    while (k < 256 && guard < 2000) begin
      v = toggle ? ((guard % 2) == 0) : 1'b1;
      x = 8'($urandom);
      y = 8'($urandom);
      ex = longint'(x) * longint'(y);
      if (mode == 1) ex = ex + 1;
      p = 16'(ex);
      if (mode == 2 && k == 37) begin
        x = -8'sd128; y = -8'sd128; p = -16'sd16384;
      end
      in_valid = v;
      start = (k == start_at) && v;
      if (k == rst_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_sum", longint'(sum_abs_err), 0);
        chk("rst_cnt", longint'(err_count), 0);
        tick();
        rst_n = 1'b1;
        res_ready = 1'b0;
        tick();
        return;
      end
      tick();
      if (v) k++;
      guard++;
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("report_reached", longint'(res_valid), 1);
    chk("lit_sum", longint'(sum_abs_err), es);
    chk("lit_max", longint'(max_abs_err), em);
    chk("lit_cnt", longint'(err_count), ec);
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("hold_valid", longint'(res_valid), 1);
      chk("hold_sum", longint'(sum_abs_err), es);
      chk("hold_max", longint'(max_abs_err), em);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("done_valid", longint'(res_valid), 0);
    chk("done_busy", longint'(busy), 0);
    chk("done_sum_held", longint'(sum_abs_err), es);
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("reset_busy", longint'(busy), 0);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_res_valid", longint'(res_valid), 0);
    chk("reset_sum", longint'(sum_abs_err), 0);
    rst_n = 1'b1;
    tick();
    run_window(0, 1'b0, -1, -1, 1, 1'b0, 0, 0, 0);
    run_window(1, 1'b0, -1, -1, 1, 1'b1, 256, 1, 256);
    run_window(2, 1'b0, -1, -1, 2, 1'b0, 32768, 32768, 1);
    run_window(1, 1'b1, -1, -1, 6, 1'b0, 256, 1, 256);
    run_window(1, 1'b0, 100, -1, 1, 1'b0, 256, 1, 256);
    run_window(1, 1'b0, -1, 50, 1, 1'b0, 0, 0, 0);
    run_window(1, 1'b0, -1, -1, 3, 1'b0, 256, 1, 256);
    run_window(0, 1'b1, -1, -1, 1, 1'b0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
